// File: rtl/sys_bridge_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : bridge_pkg
//  Purpose  : Shared definitions for the CPU-to-peripheral bridge. Holds the
//             bridge FSM state encoding, the CSR byte offsets inside the
//             bridge's own window, and the ceiling-log2 helper used to size
//             the device-index field.
//  Revision : 1.0  initial release
// ============================================================================
package bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Byte offsets of the bridge CSRs inside the CSR window.
    localparam int unsigned CSR_MASK = 32'h0;
    localparam int unsigned CSR_PEND = 32'h4;
    localparam int unsigned CSR_ERR  = 32'h8;

    // Smallest r such that 2**r >= v.
    function automatic int clog2(input int unsigned v);
        int r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sys_bridge_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : sys_bridge_if
//  Purpose  : Bundles the CPU-side and device-side signals of the bridge.
//             master : the environment (CPU plus devices)
//             slave  : the bridge itself
//  Signals  : cpu_req/we/addr/wd  -> bridge      access request from the CPU
//             cpu_rd/ack/err/busy <- bridge      completion and stall
//             dev_sel/we/addr/wd  <- bridge      device access strobes
//             dev_rd/rdy/irq      -> bridge      device responses, interrupts
//             hwint               <- bridge      CP0 hardware-interrupt vector
//  Revision : 1.0  initial release
// ============================================================================
interface sys_bridge_if #(
    parameter int N_DEV      = 4,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int DEV_SPAN_W = 4,
    parameter int HWINT_W    = 6
);
    logic                      cpu_req;
    logic                      cpu_we;
    logic [ADDR_W-1:0]         cpu_addr;
    logic [DATA_W-1:0]         cpu_wd;
    logic [DATA_W-1:0]         cpu_rd;
    logic                      cpu_ack;
    logic                      cpu_err;
    logic                      cpu_busy;
    logic [N_DEV-1:0]          dev_sel;
    logic                      dev_we;
    logic [DEV_SPAN_W-1:0]     dev_addr;
    logic [DATA_W-1:0]         dev_wd;
    logic [N_DEV*DATA_W-1:0]   dev_rd;
    logic [N_DEV-1:0]          dev_rdy;
    logic [N_DEV-1:0]          dev_irq;
    logic [HWINT_W-1:0]        hwint;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wd, dev_rd, dev_rdy, dev_irq,
        input  cpu_rd, cpu_ack, cpu_err, cpu_busy,
        input  dev_sel, dev_we, dev_addr, dev_wd, hwint
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wd, dev_rd, dev_rdy, dev_irq,
        output cpu_rd, cpu_ack, cpu_err, cpu_busy,
        output dev_sel, dev_we, dev_addr, dev_wd, hwint
    );
endinterface
`default_nettype wire

// File: rtl/sys_bridge_irq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : irq_ctrl
//  Purpose  : Interrupt aggregation for the bridge. Latches level interrupts
//             into a pending register (write-1-to-clear, set beats clear),
//             holds the interrupt mask, and registers the masked pending
//             bits onto the CP0 hardware-interrupt vector.
//  Ports    : clk, rst (async, active-low)
//             i_mask_we / i_mask_wd     mask register write
//             i_pend_clr_we / i_pend_clr  W1C clear of pending bits
//             i_irq                     per-device interrupt levels
//             o_mask, o_pend            register values for CSR reads
//             o_hwint                   registered masked pending vector
//  Revision : 1.0  initial release
// ============================================================================
module irq_ctrl #(
    parameter int N_DEV   = 4,
    parameter int HWINT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_mask_we,
    input  logic [N_DEV-1:0]   i_mask_wd,
    input  logic               i_pend_clr_we,
    input  logic [N_DEV-1:0]   i_pend_clr,
    input  logic [N_DEV-1:0]   i_irq,
    output logic [N_DEV-1:0]   o_mask,
    output logic [N_DEV-1:0]   o_pend,
    output logic [HWINT_W-1:0] o_hwint
);

    logic [N_DEV-1:0]   r_mask;
    logic [N_DEV-1:0]   r_pend;
    logic [HWINT_W-1:0] r_hwint;
    logic [N_DEV-1:0]   w_clr;

    assign w_clr = i_pend_clr_we ? i_pend_clr : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mask  <= '0;
            r_pend  <= '0;
            r_hwint <= '0;
        end else begin
            if (i_mask_we) begin
                r_mask <= i_mask_wd;
            end
            // OR-ing the new levels after the clear makes a same-cycle set win.
            r_pend  <= (r_pend & ~w_clr) | i_irq;
            // Vector bits above N_DEV stay zero through the zero-extension.
            r_hwint <= HWINT_W'(r_pend & r_mask);
        end
    end

    assign o_mask  = r_mask;
    assign o_pend  = r_pend;
    assign o_hwint = r_hwint;

endmodule
`default_nettype wire

// File: rtl/sys_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : sys_bridge
//  Purpose  : Connects the multicycle CPU's peripheral port to N_DEV
//             memory-mapped devices plus a small CSR block. Devices may
//             stretch an access with dev_rdy; an unanswered access ends in a
//             timeout error. Device interrupts feed irq_ctrl, which drives
//             the CP0 hardware-interrupt vector.
//  Ports    : clk          clock
//             rst          asynchronous, active-low reset
//             bus (slave)  CPU request/response, device strobes/responses,
//                          interrupts and hwint (see sys_bridge_if)
//  Revision : 1.0  initial release
// ============================================================================
module sys_bridge
    import bridge_pkg::*;
#(
    parameter int                N_DEV      = 4,
    parameter int                DATA_W     = 32,
    parameter int                ADDR_W     = 32,
    parameter int                DEV_SPAN_W = 4,
    parameter logic [ADDR_W-1:0] BASE       = ADDR_W'(32'h0000_7F00),
    parameter int                TIMEOUT    = 15,
    parameter int                HWINT_W    = 6
) (
    input  logic        clk,
    input  logic        rst,
    sys_bridge_if.slave bus
);

    localparam int IDX_W = clog2(N_DEV + 1);
    localparam int CNT_W = clog2(TIMEOUT + 2);

    localparam int                 c_dec_lo   = DEV_SPAN_W + IDX_W;
    localparam logic [IDX_W-1:0]   c_idx_csr  = IDX_W'(N_DEV);
    // The access window spans TIMEOUT+2 ACCESS cycles (counter 0..TIMEOUT+1),
    // so an unanswered request is acked TIMEOUT+3 cycles after it was taken.
    localparam logic [CNT_W-1:0]   c_cnt_last = CNT_W'(TIMEOUT + 1);

    state_t                  r_state;
    logic [IDX_W-1:0]        r_idx;
    logic [CNT_W-1:0]        r_cnt;
    logic [ADDR_W-1:0]       r_addr;
    logic [ADDR_W-1:0]       r_err_addr;
    logic [DATA_W-1:0]       r_cpu_rd;
    logic                    r_cpu_ack;
    logic                    r_cpu_err;
    logic                    r_cpu_busy;
    logic [N_DEV-1:0]        r_dev_sel;
    logic                    r_dev_we;
    logic [DEV_SPAN_W-1:0]   r_dev_addr;
    logic [DATA_W-1:0]       r_dev_wd;

    logic                    w_hit;
    logic [IDX_W-1:0]        w_idx;
    logic [DEV_SPAN_W-1:0]   w_off;
    logic                    w_csr_acc;
    logic                    w_mask_we;
    logic                    w_pend_clr_we;
    logic [DATA_W-1:0]       w_csr_rd;
    logic                    w_sel_rdy;
    logic [DATA_W-1:0]       w_sel_rd;
    logic [N_DEV-1:0]        w_mask;
    logic [N_DEV-1:0]        w_pend;
    logic [HWINT_W-1:0]      w_hwint;

    // ---------------------------------------------------------------- decode
    assign w_hit = (bus.cpu_addr[ADDR_W-1:c_dec_lo] == BASE[ADDR_W-1:c_dec_lo]);
    assign w_idx = bus.cpu_addr[c_dec_lo-1:DEV_SPAN_W];
    assign w_off = bus.cpu_addr[DEV_SPAN_W-1:0];

    // CSR accesses complete in the request cycle itself.
    assign w_csr_acc     = (r_state == ST_IDLE) && bus.cpu_req && w_hit && (w_idx == c_idx_csr);
    assign w_mask_we     = w_csr_acc && bus.cpu_we && (w_off == DEV_SPAN_W'(CSR_MASK));
    assign w_pend_clr_we = w_csr_acc && bus.cpu_we && (w_off == DEV_SPAN_W'(CSR_PEND));

    always_comb begin
        w_csr_rd = '0;
        if (w_off == DEV_SPAN_W'(CSR_MASK)) begin
            w_csr_rd = DATA_W'(w_mask);
        end else if (w_off == DEV_SPAN_W'(CSR_PEND)) begin
            w_csr_rd = DATA_W'(w_pend);
        end else if (w_off == DEV_SPAN_W'(CSR_ERR)) begin
            w_csr_rd = DATA_W'(r_err_addr);
        end
    end

    // Only the selected device's ready and read slice are looked at.
    always_comb begin
        w_sel_rdy = 1'b0;
        w_sel_rd  = '0;
        for (int i = 0; i < N_DEV; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_sel_rdy = bus.dev_rdy[i];
                w_sel_rd  = bus.dev_rd[i*DATA_W +: DATA_W];
            end
        end
    end

    // ------------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_err_addr <= '0;
            r_cpu_rd   <= '0;
            r_cpu_ack  <= 1'b0;
            r_cpu_err  <= 1'b0;
            r_cpu_busy <= 1'b0;
            r_dev_sel  <= '0;
            r_dev_we   <= 1'b0;
            r_dev_addr <= '0;
            r_dev_wd   <= '0;
        end else begin
            r_cpu_ack <= 1'b0;
            r_cpu_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.cpu_req) begin
                        r_addr <= bus.cpu_addr;
                        if (!w_hit || (w_idx > c_idx_csr)) begin
                            r_state    <= ST_DONE;
                            r_cpu_ack  <= 1'b1;
                            r_cpu_err  <= 1'b1;
                            r_cpu_rd   <= '0;
                            r_err_addr <= bus.cpu_addr;
                        end else if (w_idx == c_idx_csr) begin
                            r_state   <= ST_DONE;
                            r_cpu_ack <= 1'b1;
                            r_cpu_rd  <= bus.cpu_we ? '0 : w_csr_rd;
                        end else begin
                            r_state    <= ST_ACCESS;
                            r_cnt      <= '0;
                            r_idx      <= w_idx;
                            r_cpu_busy <= 1'b1;
                            r_dev_sel  <= N_DEV'(1) << w_idx;
                            r_dev_we   <= bus.cpu_we;
                            r_dev_addr <= w_off;
                            r_dev_wd   <= bus.cpu_wd;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (w_sel_rdy) begin
                        r_state    <= ST_DONE;
                        r_cpu_ack  <= 1'b1;
                        r_cpu_rd   <= w_sel_rd;
                        r_cpu_busy <= 1'b0;
                        r_dev_sel  <= '0;
                        r_dev_we   <= 1'b0;
                    end else if (r_cnt == c_cnt_last) begin
                        r_state    <= ST_DONE;
                        r_cpu_ack  <= 1'b1;
                        r_cpu_err  <= 1'b1;
                        r_cpu_rd   <= '0;
                        r_err_addr <= r_addr;
                        r_cpu_busy <= 1'b0;
                        r_dev_sel  <= '0;
                        r_dev_we   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    // Requests arriving during the ack cycle are dropped.
                    r_state  <= ST_IDLE;
                    r_cpu_rd <= '0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------- interrupts
    irq_ctrl #(
        .N_DEV   (N_DEV),
        .HWINT_W (HWINT_W)
    ) u_irq_ctrl (
        .clk           (clk),
        .rst           (rst),
        .i_mask_we     (w_mask_we),
        .i_mask_wd     (bus.cpu_wd[N_DEV-1:0]),
        .i_pend_clr_we (w_pend_clr_we),
        .i_pend_clr    (bus.cpu_wd[N_DEV-1:0]),
        .i_irq         (bus.dev_irq),
        .o_mask        (w_mask),
        .o_pend        (w_pend),
        .o_hwint       (w_hwint)
    );

    assign bus.cpu_rd   = r_cpu_rd;
    assign bus.cpu_ack  = r_cpu_ack;
    assign bus.cpu_err  = r_cpu_err;
    assign bus.cpu_busy = r_cpu_busy;
    assign bus.dev_sel  = r_dev_sel;
    assign bus.dev_we   = r_dev_we;
    assign bus.dev_addr = r_dev_addr;
    assign bus.dev_wd   = r_dev_wd;
    assign bus.hwint    = w_hwint;

endmodule
`default_nettype wire
